// File: rtl/uart_tx_interface.sv
// ---------------------------------------------------------------------------
// uart_tx_interface
//
// 8N1 UART transmitter returning result bytes from the CPU datapath to the
// host. Bytes arrive over a valid/ready handshake into a one-entry holding
// register and are serialized LSB-first as 1 start, 8 data and 1 stop bit.
// A byte already waiting at the end of a stop bit starts the next frame on
// the very next edge, so back-to-back frames carry no idle gap.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2), 868 = 100 MHz / 115200
//
// Ports
//   CLK           system clock, rising edge
//   RST           asynchronous active-high reset; aborts any frame at once
//   Tx_Byte_in    byte to send, sampled on the accept edge
//   Tx_Valid_in   upstream presents a byte
//   Tx_Ready_out  holding register empty (accept = valid && ready)
//   Tx_Busy_out   frame in progress
//   Tx_Done_out   one-cycle pulse on the last cycle of every stop bit
//   TX_out        serial line, idles high
// ---------------------------------------------------------------------------
module uart_tx_interface #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] Tx_Byte_in,
   input  logic       Tx_Valid_in,
   output logic       Tx_Ready_out,
   output logic       Tx_Busy_out,
   output logic       Tx_Done_out,
   output logic       TX_out
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shift_reg, shift_reg_n;
   logic [7:0]       hold_byte;
   logic             hold_valid;
   logic             accept;
   logic             load;
   logic             bit_last;
   logic             tx_n;
   logic             done_n;

   // Ready comes straight from the holding flag, never from Tx_Valid_in.
   assign Tx_Ready_out = ~hold_valid;
   assign accept       = Tx_Valid_in & ~hold_valid;
   assign bit_last     = (baud_cnt == CNT_LAST);

   // ---- next-state / next-output logic ------------------------------------
   always_comb begin
      state_n     = state;
      baud_cnt_n  = baud_cnt;
      bit_idx_n   = bit_idx;
      shift_reg_n = shift_reg;
      load        = 1'b0;
      tx_n        = 1'b1;
      done_n      = 1'b0;

      case (state)
         IDLE: begin
            baud_cnt_n = '0;
            bit_idx_n  = '0;
            if (hold_valid) begin
               load        = 1'b1;
               shift_reg_n = hold_byte;
               state_n     = START;
            end
         end
         START: begin
            if (bit_last) begin
               baud_cnt_n = '0;
               bit_idx_n  = '0;
               state_n    = DATA;
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_last) begin
               baud_cnt_n  = '0;
               shift_reg_n = {1'b0, shift_reg[7:1]};
               if (bit_idx == 3'd7) begin
                  bit_idx_n = '0;
                  state_n   = STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_last) begin
               baud_cnt_n = '0;
               bit_idx_n  = '0;
               // A waiting byte chains straight into the next start bit.
               if (hold_valid) begin
                  load        = 1'b1;
                  shift_reg_n = hold_byte;
                  state_n     = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               baud_cnt_n = baud_cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Outputs are registered, so they are derived from the next state.
      case (state_n)
         IDLE:    tx_n = 1'b1;
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_reg_n[0];
         STOP:    tx_n = 1'b1;
         default: tx_n = 1'b1;
      endcase
      done_n = (state_n == STOP) && (baud_cnt_n == CNT_LAST);
   end

   // ---- control state and registered outputs -------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         baud_cnt    <= '0;
         bit_idx     <= '0;
         hold_valid  <= 1'b0;
         TX_out      <= 1'b1;
         Tx_Busy_out <= 1'b0;
         Tx_Done_out <= 1'b0;
      end else begin
         state       <= state_n;
         baud_cnt    <= baud_cnt_n;
         bit_idx     <= bit_idx_n;
         // accept and load are exclusive: load needs hold_valid, accept needs it clear.
         hold_valid  <= accept | (hold_valid & ~load);
         TX_out      <= tx_n;
         Tx_Busy_out <= (state_n != IDLE);
         Tx_Done_out <= done_n;
      end
   end

   // ---- data registers (qualified by control, no reset needed) -------------
   always_ff @(posedge CLK) begin
      if (accept) begin
         hold_byte <= Tx_Byte_in;
      end
      shift_reg <= shift_reg_n;
   end

endmodule

// File: tb/tb_uart_tx_interface.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_interface
//
// Directed bench for uart_tx_interface with CLKS_PER_BIT = 4. The stimulus
// thread queues each byte it expects on the line; a separate monitor decodes
// every frame from TX_out, checks its shape and the Done/Busy outputs, and
// pops the queue to compare the byte. Timing points are checked inline.
// ---------------------------------------------------------------------------
module tb_uart_tx_interface;

   localparam int CPB = 4;

   logic       CLK;
   logic       RST;
   logic [7:0] Tx_Byte_in;
   logic       Tx_Valid_in;
   logic       Tx_Ready_out;
   logic       Tx_Busy_out;
   logic       Tx_Done_out;
   logic       TX_out;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         mon_pos = 0;
   logic [7:0] exp_q[$];

   uart_tx_interface #(.CLKS_PER_BIT(CPB)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .Tx_Byte_in   (Tx_Byte_in),
      .Tx_Valid_in  (Tx_Valid_in),
      .Tx_Ready_out (Tx_Ready_out),
      .Tx_Busy_out  (Tx_Busy_out),
      .Tx_Done_out  (Tx_Done_out),
      .TX_out       (TX_out)
   );

   initial begin
      CLK = 1'b0;
      #5;
      forever #5 CLK = ~CLK;
   end

   // cyc == k at the negedge following rising edge number k
   initial begin
      forever begin
         @(posedge CLK);
         cyc++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_to(input int e);
      int n = 0;
      while (cyc < e && n < 500) begin
         @(negedge CLK);
         n++;
      end
      if (cyc != e) chk("wait_to", cyc, e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || mon_pos != 0 || Tx_Busy_out) && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk("idle_reached", int'(n < 200), 1);
   endtask

   // Called at a negedge with the holding register expected empty;
   // returns at the negedge after accept edge k.
   task automatic accept_now(input logic [7:0] b, output int k);
      chk("accept_ready", Tx_Ready_out, 1);
      Tx_Byte_in  = b;
      Tx_Valid_in = 1'b1;
      exp_q.push_back(b);
      k = cyc + 1;
      @(negedge CLK);
      Tx_Valid_in = 1'b0;
   endtask

   // ---- frame monitor ------------------------------------------------------
   initial begin
      logic [7:0] mon_byte;
      int         shape_err;
      int         b;
      int         ph;
      mon_byte  = '0;
      shape_err = 0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            mon_pos = 0;
         end else begin
            if (mon_pos == 0) begin
               if (Tx_Done_out) chk("done_while_idle", Tx_Done_out, 0);
               if (TX_out === 1'b0) begin
                  mon_pos   = 1;
                  shape_err = 0;
                  mon_byte  = '0;
               end
            end
            if (mon_pos > 0) begin
               b  = (mon_pos - 1) / CPB;
               ph = (mon_pos - 1) % CPB;
               if (b == 0) begin
                  if (TX_out !== 1'b0) shape_err = 1;
               end else if (b == 9) begin
                  if (TX_out !== 1'b1) shape_err = 1;
               end else begin
                  if (ph == 0) mon_byte[b-1] = TX_out;
                  else if (TX_out !== mon_byte[b-1]) shape_err = 1;
               end
               if (Tx_Done_out !== (mon_pos == 10 * CPB)) shape_err = 1;
               if (Tx_Busy_out !== 1'b1) shape_err = 1;
               if (mon_pos == 10 * CPB) begin
                  chk("frame_shape", shape_err, 0);
                  if (exp_q.size() == 0) chk("frame_unexpected", int'(mon_byte), -1);
                  else chk("frame_byte", int'(mon_byte), int'(exp_q.pop_front()));
                  mon_pos = 0;
               end else begin
                  mon_pos++;
               end
            end
         end
      end
   end

   // ---- stimulus -----------------------------------------------------------
   initial begin
      int k;
      int busy_cnt;
      int bp_err;
      RST         = 1'b0;
      Tx_Valid_in = 1'b0;
      Tx_Byte_in  = '0;

      // Reset with no clock edge yet
      #2 RST = 1'b1;
      #1;
      chk("rst_tx", TX_out, 1);
      chk("rst_ready", Tx_Ready_out, 1);
      chk("rst_busy", Tx_Busy_out, 0);
      chk("rst_done", Tx_Done_out, 0);
      repeat (3) @(posedge CLK);
      #2 RST = 1'b0;
      @(negedge CLK);
      chk("post_rst_tx", TX_out, 1);

      // Single byte 0xA5
      accept_now(8'hA5, k);
      chk("a5_ready_low", Tx_Ready_out, 0);
      wait_to(k + 1);
      chk("a5_start_tx", TX_out, 0);
      chk("a5_busy_rise", Tx_Busy_out, 1);
      chk("a5_ready_back", Tx_Ready_out, 1);
      wait_to(k + 5);
      chk("a5_bit0", TX_out, 1);
      wait_to(k + 39);
      chk("a5_done_early", Tx_Done_out, 0);
      wait_to(k + 40);
      chk("a5_done", Tx_Done_out, 1);
      wait_to(k + 41);
      chk("a5_busy_fall", Tx_Busy_out, 0);
      chk("a5_done_fall", Tx_Done_out, 0);
      chk("a5_idle_tx", TX_out, 1);
      wait_idle();

      // Back-to-back 0x00 then 0xFF
      accept_now(8'h00, k);
      wait_to(k + 1);
      chk("b2b_ready_k1", Tx_Ready_out, 1);
      Tx_Byte_in  = 8'hFF;
      Tx_Valid_in = 1'b1;
      exp_q.push_back(8'hFF);
      busy_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         busy_cnt += int'(Tx_Busy_out);
         if (cyc == k + 2) Tx_Valid_in = 1'b0;
         if (cyc == k + 40) chk("b2b_ready_held", Tx_Ready_out, 0);
         if (cyc == k + 41) begin
            chk("b2b_ready_back", Tx_Ready_out, 1);
            chk("b2b_no_gap", TX_out, 0);
         end
         @(negedge CLK);
      end
      chk("b2b_busy_cycles", busy_cnt, 80);
      chk("b2b_busy_fall", Tx_Busy_out, 0);
      wait_idle();

      // Backpressure: valid held high, byte changing every cycle
      chk("bp_ready", Tx_Ready_out, 1);
      Tx_Byte_in  = 8'h5A;
      Tx_Valid_in = 1'b1;
      exp_q.push_back(8'h5A);
      k = cyc + 1;
      bp_err = 0;
      for (int j = 0; j <= 41; j++) begin
         @(negedge CLK);
         if (j == 0) begin
            chk("bp_ready_low0", Tx_Ready_out, 0);
            Tx_Byte_in = 8'hC3;
         end else if (j == 1) begin
            chk("bp_ready_high1", Tx_Ready_out, 1);
            Tx_Byte_in = 8'h96;
            exp_q.push_back(8'h96);
         end else if (j <= 40) begin
            if (Tx_Ready_out !== 1'b0) bp_err++;
            Tx_Byte_in = 8'(16 + j);
         end else begin
            Tx_Valid_in = 1'b0;
         end
      end
      chk("bp_no_accept_while_full", bp_err, 0);
      wait_idle();
      chk("bp_queue_empty", exp_q.size(), 0);

      // Reset in the middle of data bit 3, with 0x77 pending
      accept_now(8'h3C, k);
      wait_to(k + 1);
      Tx_Byte_in  = 8'h77;
      Tx_Valid_in = 1'b1;
      exp_q.push_back(8'h77);
      wait_to(k + 2);
      Tx_Valid_in = 1'b0;
      wait_to(k + 18);
      chk("rstd_bit3", TX_out, 1);
      chk("rstd_pending", Tx_Ready_out, 0);
      #2 RST = 1'b1;
      #1;
      chk("rstd_tx", TX_out, 1);
      chk("rstd_busy", Tx_Busy_out, 0);
      chk("rstd_done", Tx_Done_out, 0);
      chk("rstd_ready", Tx_Ready_out, 1);
      exp_q.delete();
      repeat (2) @(posedge CLK);
      #2 RST = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("rstd_release_tx", TX_out, 1);
      chk("rstd_release_busy", Tx_Busy_out, 0);
      accept_now(8'h81, k);
      wait_idle();
      chk("rstd_queue_empty", exp_q.size(), 0);

      // Accept on the final stop cycle with nothing pending
      accept_now(8'h4B, k);
      wait_to(k + 40);
      chk("sf_done", Tx_Done_out, 1);
      chk("sf_ready", Tx_Ready_out, 1);
      Tx_Byte_in  = 8'hD2;
      Tx_Valid_in = 1'b1;
      exp_q.push_back(8'hD2);
      wait_to(k + 41);
      Tx_Valid_in = 1'b0;
      chk("sf_gap_tx", TX_out, 1);
      chk("sf_gap_busy", Tx_Busy_out, 0);
      chk("sf_gap_ready", Tx_Ready_out, 0);
      wait_to(k + 42);
      chk("sf_start_tx", TX_out, 0);
      chk("sf_start_busy", Tx_Busy_out, 1);
      wait_idle();
      chk("final_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_interface.md
# uart_tx_interface

Serial UART transmitter that returns result bytes from the CPU datapath to the host over the TX line. It is the transmit counterpart of the RX UART interface that feeds instruction bytes into the instruction memory. It accepts bytes through a valid/ready handshake into a one-entry holding register and serializes them as 8N1 frames (1 start, 8 data LSB-first, 1 stop), with back-to-back frames and no idle gap.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range ≥ 2.
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- Tx_Byte_in  input  8  byte to transmit; sampled on the accept edge.
- Tx_Valid_in  input  1  upstream has a byte on Tx_Byte_in.
- Tx_Ready_out  output  1  holding register empty; accept occurs on a rising edge where Tx_Valid_in && Tx_Ready_out.
- Tx_Busy_out  output  1  frame in progress (state ≠ IDLE).
- Tx_Done_out  output  1  one-cycle pulse on the last cycle of each stop bit.
- TX_out  output  1  serial line; idles high.

## Operation
- Reset values (asynchronous while RST=1): TX_out=1, Tx_Ready_out=1, Tx_Busy_out=0, Tx_Done_out=0, state=IDLE, holding register empty, baud counter=0, bit index=0.
- Holding register:
  - Accept writes Tx_Byte_in to the register and sets hold_valid.
  - Tx_Ready_out = !hold_valid, driven from registered state only (no combinational path from Tx_Valid_in).
  - Tx_Valid_in while Tx_Ready_out=0 is ignored. Upstream holds the byte until accepted.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX_out=1. If hold_valid: load the shift register from holding, clear hold_valid, go to START, baud counter=0.
  - START: TX_out=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
  - DATA: TX_out=shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment bit index. After bit 7 completes, go to STOP.
  - STOP: TX_out=1 for CLKS_PER_BIT cycles. On the final cycle, Tx_Done_out=1. If hold_valid, load the shift register, clear hold_valid, and go directly to START. Otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary. Width is clog2(CLKS_PER_BIT).
- Simultaneous accept and load, in IDLE or on the STOP final cycle with hold_valid=1: the holding register is loaded with the new byte and hold_valid stays 1, so the register never drops a byte. This is legal only because Tx_Ready_out=0 in that case, so it never occurs. The bench must confirm no accept happens when hold_valid=1.
- Accept on the STOP final cycle while hold_valid=0: the byte is registered at that edge and the FSM enters IDLE, then START one cycle later. This gives one idle-high cycle between frames.
- Reset mid-frame aborts immediately. TX_out returns high asynchronously and the pending holding byte is discarded.
- TX_out, Tx_Busy_out and Tx_Done_out are registered outputs (no glitches).

## Timing
- Accept on edge k. If the FSM is IDLE, state=START and TX_out=0 from edge k+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles: start bit from edge k+1, data bit n from edge k+1+(n+1)·CLKS_PER_BIT, stop bit from edge k+1+9·CLKS_PER_BIT.
- Tx_Done_out is high for exactly one cycle, the cycle before edge k+1+10·CLKS_PER_BIT.
- Tx_Ready_out returns to 1 at edge k+1 (holding register drained into the shift register). A second byte can be accepted during the first frame.
- Back-to-back frames: with hold_valid=1 at the STOP final cycle, the next start bit begins on the very next edge. Tx_Busy_out stays 1 continuously.
- Tx_Busy_out rises at edge k+1 and falls at the edge after the last STOP cycle when there is no pending byte.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: assert RST mid-cycle with no clock → TX_out=1, Tx_Ready_out=1, Tx_Busy_out=0, Tx_Done_out=0 immediately.
- Single byte 0xA5: accept at edge k → TX_out holds 0,1,0,1,0,0,1,0,1,1 for 4 cycles each, starting at edge k+1. Tx_Done_out is high only in cycle k+40. Tx_Busy_out falls at edge k+41.
- Back-to-back 0x00 then 0xFF: second byte accepted at edge k+2 → Tx_Ready_out=0 until edge k+41. The 0xFF start bit begins at edge k+41 with no idle cycle. Total 80 busy cycles.
- Backpressure: hold Tx_Valid_in=1 with a changing Tx_Byte_in while Tx_Ready_out=0 → only the byte present on the ready edge is transmitted. There are no duplicate or extra frames.
- Reset mid-DATA: send 0x3C, assert RST during bit 3 → TX_out=1 at once and no Tx_Done_out pulse. After release, a new byte 0x81 transmits correctly and the old pending byte never appears.
- Accept on the STOP final cycle: Tx_Done_out=1 and no pending byte → exactly one idle-high cycle, then a start bit. The frame content is correct.
